commut_reader: RTL

Read-side sequencer for the 20-word commutation buffer. On each rising edge of the writer's `full` flag it waits out the writer's address-bus hold-off. It then reads the buffer word by word over the shared tri-state address bus, issuing one read strobe per word. Each captured word is handed downstream with a valid/ready handshake. It sits between the buffer RAM and the frame transmitter, and releases the bus once a frame is drained.

---
 rtl/commut_reader_if.sv | 24 ++
 rtl/commut_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/commut_reader_if.sv
// -----------------------------------------------------------------------------
// commut_reader_if
// Groups the buffer-RAM read strobe/data and the downstream valid/ready word
// channel used by commut_reader.
//   RE      : RAM read strobe (reader -> RAM)
//   rdData  : RAM read data, valid the cycle after RE (RAM -> reader)
//   dOut    : word to the frame transmitter (reader -> downstream)
//   dValid  : dOut valid (reader -> downstream)
//   dReady  : downstream ready (downstream -> reader)
// The shared tri-state address bus is not carried here; it stays a plain net
// port on the reader so it can be resolved alongside the writer's driver.
// -----------------------------------------------------------------------------
interface commut_reader_if #(
  parameter int DW = 16
) ();
  logic          RE;
  logic [DW-1:0] rdData;
  logic [DW-1:0] dOut;
  logic          dValid;
  logic          dReady;

  modport master (output RE, dOut, dValid, input rdData, dReady);
  modport slave  (input RE, dOut, dValid, output rdData, dReady);
endinterface

// File: rtl/commut_reader.sv
// -----------------------------------------------------------------------------
// commut_reader
// Read-side sequencer for the commutation buffer. A rising edge on the
// writer's full flag starts a frame: wait HOLDOFF cycles for the writer to
// release the shared address bus, then read WORDS words one at a time and hand
// each downstream over a valid/ready handshake. The bus is released at the end
// of the frame and done pulses for one cycle.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   full     : frame-complete flag from the writer (asynchronous, synchronised)
//   bus      : commut_reader_if.master (RE, rdData, dOut, dValid, dReady)
//   rdAdr    : shared tri-state address bus, driven in ADDR/LATCH/SEND only
//   busy     : frame in progress, HOLD through END
//   done     : one-cycle end-of-frame pulse
//   overrun  : sticky; a full edge arrived while a frame was in progress
//
// Optional feature: define COMMUT_RD_CHECKSUM_EN to append one extra word,
// the modulo-2^DW sum of the frame, after the last data word.
// -----------------------------------------------------------------------------
module commut_reader #(
  parameter int WORDS   = 20,
  parameter int DW      = 16,
  parameter int AW      = 5,
  parameter int HOLDOFF = 66
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            full,
  commut_reader_if.master bus,
  output wire  [AW-1:0]   rdAdr,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam int CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ADDR,
    S_LATCH,
    S_SEND,
    S_CSUM,
    S_END
  } state_t;

  // full synchroniser: [0],[1] resynchronise, [2] holds the previous value
  // so that only a rising edge (not a held level) starts a frame.
  logic [2:0] full_s_q, full_s_d;
  logic       edge_q, edge_d;

  always_comb begin
    full_s_d = {full_s_q[1:0], full};
    edge_d   = full_s_q[1] & ~full_s_q[2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_s_q <= '0;
      edge_q   <= 1'b0;
    end else begin
      full_s_q <= full_s_d;
      edge_q   <= edge_d;
    end
  end

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   idx_q;
  logic            re_q;
  logic            dvalid_q;
  logic [DW-1:0]   dout_q;
  logic            busy_q;
  logic            done_q;
  logic            overrun_q;
`ifdef COMMUT_RD_CHECKSUM_EN
  logic [DW-1:0]   sum_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      re_q      <= 1'b0;
      dvalid_q  <= 1'b0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef COMMUT_RD_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      // RE and done are single-cycle pulses raised only on state entry.
      re_q   <= 1'b0;
      done_q <= 1'b0;

      if (edge_q && (state_q != S_IDLE))
        overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (edge_q) begin
            overrun_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
`ifdef COMMUT_RD_CHECKSUM_EN
            sum_q     <= '0;
`endif
            state_q   <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (cnt_q == CW'(HOLDOFF - 1)) begin
            idx_q   <= '0;
            re_q    <= 1'b1;
            state_q <= S_ADDR;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_ADDR: state_q <= S_LATCH;

        // rdData is valid in this cycle, one cycle after the strobe.
        S_LATCH: begin
          dout_q   <= bus.rdData;
          dvalid_q <= 1'b1;
          state_q  <= S_SEND;
        end

        S_SEND: begin
          if (bus.dReady) begin
            dvalid_q <= 1'b0;
`ifdef COMMUT_RD_CHECKSUM_EN
            sum_q    <= sum_q + dout_q;
`endif
            if (idx_q == AW'(WORDS - 1)) begin
`ifdef COMMUT_RD_CHECKSUM_EN
              // The last word is still in dout_q, so fold it in here.
              dout_q   <= sum_q + dout_q;
              dvalid_q <= 1'b1;
              state_q  <= S_CSUM;
`else
              done_q   <= 1'b1;
              state_q  <= S_END;
`endif
            end else begin
              idx_q   <= idx_q + AW'(1);
              re_q    <= 1'b1;
              state_q <= S_ADDR;
            end
          end
        end

        S_CSUM: begin
          if (bus.dReady) begin
            dvalid_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_END;
          end
        end

        S_END: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The bus is owned only while a data word is being addressed or offered;
  // HOLD, CSUM and END leave it floating.
  logic drive;
  assign drive = (state_q == S_ADDR) || (state_q == S_LATCH) || (state_q == S_SEND);
  assign rdAdr = drive ? idx_q : {AW{1'bz}};

  assign bus.RE     = re_q;
  assign bus.dOut   = dout_q;
  assign bus.dValid = dvalid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule
